// File: rtl/cluster_unpacker.sv
// cluster_unpacker
//   Expands a frame of eight (address, size) cluster descriptors into a
//   strip hit map. One cluster is unpacked per cycle, so a frame takes
//   eight UNPACK cycles plus one DONE cycle in which the finished map is
//   published.
//
// Ports
//   clock        sole clock, rising edge
//   reset        asynchronous, active-high
//   frame_valid  one-cycle strobe, frame present on adr_in/cnt_in
//   adr_in       eight cluster addresses, cluster k at [k*MXADRBITS +: MXADRBITS]
//   cnt_in       eight cluster sizes (strips-1), cluster k at [k*MXCNTBITS +: MXCNTBITS]
//   ready        high when a frame can be accepted
//   vpfs_out     reconstructed hit map, bit n = strip n
//   vpfs_valid   one-cycle strobe, vpfs_out/nclusters updated this cycle
//   nclusters    in-range clusters in the last completed frame
//   err_cnt      saturating count of out-of-range clusters
//                (only when CLUSTER_UNPACKER_ERRCNT_EN is defined)
//
// Build option
//   CLUSTER_UNPACKER_ERRCNT_EN : adds the err_cnt output and its counter.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a frame, ready=1
// UNPACK | expanding cluster[idx] into the working map, ready=0
// DONE   | map published (vpfs_valid=1), ready=1, may accept next frame

module cluster_unpacker #(
  parameter int MXADRBITS = 11,
  parameter int MXCNTBITS = 3,
  parameter int NSTRIPS   = 1536
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_valid,
  input  logic [8*MXADRBITS-1:0]   adr_in,
  input  logic [8*MXCNTBITS-1:0]   cnt_in,
  output logic                     ready,
  output logic [NSTRIPS-1:0]       vpfs_out,
  output logic                     vpfs_valid,
  output logic [3:0]               nclusters
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
  ,
  output logic [7:0]               err_cnt
`endif
);

  localparam int RUNW = 1 << MXCNTBITS;
  localparam logic [MXADRBITS:0] NSTRIPS_C = (MXADRBITS+1)'(NSTRIPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic [2:0]               idx_q, idx_d;
  logic [8*MXADRBITS-1:0]   adr_lat_q, adr_lat_d;
  logic [8*MXCNTBITS-1:0]   cnt_lat_q, cnt_lat_d;
  logic [NSTRIPS-1:0]       work_map_q, work_map_d;
  logic [3:0]               clu_cnt_q, clu_cnt_d;
  logic [NSTRIPS-1:0]       vpfs_out_q, vpfs_out_d;
  logic                     vpfs_valid_q, vpfs_valid_d;
  logic [3:0]               nclusters_q, nclusters_d;
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
  logic [7:0]               err_cnt_q, err_cnt_d;
`endif

  logic [MXADRBITS-1:0]     adr_slot [8];
  logic [MXCNTBITS-1:0]     cnt_slot [8];
  logic [MXADRBITS-1:0]     cur_adr;
  logic [MXCNTBITS-1:0]     cur_cnt;
  logic [RUNW-1:0]          run;
  logic [NSTRIPS+RUNW-1:0]  run_vec;
  logic                     is_null;
  logic                     is_hit;
  logic                     is_oor;
  logic                     accept;

  // Current cluster decode and its strip run.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      adr_slot[k] = adr_lat_q[k*MXADRBITS +: MXADRBITS];
      cnt_slot[k] = cnt_lat_q[k*MXCNTBITS +: MXCNTBITS];
    end
    cur_adr = adr_slot[idx_q];
    cur_cnt = cnt_slot[idx_q];
    for (int i = 0; i < RUNW; i++) begin
      run[i] = (i <= int'(cur_cnt));
    end
    // The run is shifted into a vector RUNW bits wider than the map, so
    // anything past the last strip falls off the top instead of wrapping.
    run_vec = {{NSTRIPS{1'b0}}, run} << cur_adr;
    is_null = &cur_adr;
    is_hit  = !is_null && ({1'b0, cur_adr} < NSTRIPS_C);
    is_oor  = !is_null && !is_hit;
  end

  assign accept = frame_valid && ready_q;

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    idx_d        = idx_q;
    adr_lat_d    = adr_lat_q;
    cnt_lat_d    = cnt_lat_q;
    work_map_d   = work_map_q;
    clu_cnt_d    = clu_cnt_q;
    vpfs_out_d   = vpfs_out_q;
    vpfs_valid_d = 1'b0;
    nclusters_d  = nclusters_q;
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
    err_cnt_d    = err_cnt_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          adr_lat_d  = adr_in;
          cnt_lat_d  = cnt_in;
          work_map_d = '0;
          clu_cnt_d  = '0;
          idx_d      = '0;
          state_d    = UNPACK;
          ready_d    = 1'b0;
        end else begin
          state_d    = IDLE;
          ready_d    = 1'b1;
        end
      end

      UNPACK: begin
        if (is_hit) begin
          work_map_d = work_map_q | run_vec[NSTRIPS-1:0];
          clu_cnt_d  = clu_cnt_q + 4'd1;
        end
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
        if (is_oor && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
`endif
        idx_d = idx_q + 3'd1;
        // Last slot: publish including this cycle's contribution.
        if (idx_q == 3'd7) begin
          state_d      = DONE;
          ready_d      = 1'b1;
          vpfs_out_d   = work_map_d;
          nclusters_d  = clu_cnt_d;
          vpfs_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      idx_q        <= '0;
      adr_lat_q    <= '0;
      cnt_lat_q    <= '0;
      work_map_q   <= '0;
      clu_cnt_q    <= '0;
      vpfs_out_q   <= '0;
      vpfs_valid_q <= 1'b0;
      nclusters_q  <= '0;
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      idx_q        <= idx_d;
      adr_lat_q    <= adr_lat_d;
      cnt_lat_q    <= cnt_lat_d;
      work_map_q   <= work_map_d;
      clu_cnt_q    <= clu_cnt_d;
      vpfs_out_q   <= vpfs_out_d;
      vpfs_valid_q <= vpfs_valid_d;
      nclusters_q  <= nclusters_d;
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign ready      = ready_q;
  assign vpfs_out   = vpfs_out_q;
  assign vpfs_valid = vpfs_valid_q;
  assign nclusters  = nclusters_q;
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_cluster_unpacker.sv
// Testbench for cluster_unpacker: directed and random frames, with a
// queue of expected maps filled by the driver and drained by a monitor.

module tb_cluster_unpacker;

  logic          clk;
  logic          rst;
  logic          fv;
  logic [87:0]   adr_in;
  logic [23:0]   cnt_in;
  logic          ready;
  logic [1535:0] vpfs_out;
  logic          vpfs_valid;
  logic [3:0]    nclusters;
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
  logic [7:0]    err_cnt;
`endif

  cluster_unpacker dut (
    .clock       (clk),
    .reset       (rst),
    .frame_valid (fv),
    .adr_in      (adr_in),
    .cnt_in      (cnt_in),
    .ready       (ready),
    .vpfs_out    (vpfs_out),
    .vpfs_valid  (vpfs_valid),
    .nclusters   (nclusters)
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1535:0] map;
    int            ncl;
    int            err;
    int            acc_edge;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            busy_until = 0;
  int            exp_err = 0;
  logic [1535:0] hold_map = '0;
  int            hold_ncl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_map(input string name, input logic [1535:0] act, input logic [1535:0] req);
    int first;
    checks++;
    if (act !== req) begin
      errors++;
      first = -1;
      for (int i = 0; i < 1536; i++) begin
        if (first < 0 && act[i] !== req[i]) first = i;
      end
      $display("FAIL %s: first differing strip %0d actual bit %b required bit %b, popcount actual %0d required %0d (t=%0t)",
               name, first, act[first], req[first], $countones(act), $countones(req), $time);
    end
  endtask

  // Reference: direct reading of the cluster rules over strip numbers.
  function automatic void ref_model(input logic [87:0] a, input logic [23:0] c,
                                    output logic [1535:0] m, output int n, output int oor);
    int aa, cc;
    m = '0; n = 0; oor = 0;
    for (int k = 0; k < 8; k++) begin
      aa = int'(a[11*k +: 11]);
      cc = int'(c[3*k +: 3]);
      if (aa == 2047) continue;
      if (aa >= 1536) begin
        oor++;
        continue;
      end
      n++;
      for (int s = aa; s <= aa + cc; s++) begin
        if (s < 1536) m[s] = 1'b1;
      end
    end
  endfunction

  // Presents a frame for one edge; accepts it in the model only if the
  // previous frame has reached its DONE cycle (9 edges after its accept).
  task automatic issue(input logic [87:0] a, input logic [23:0] c);
    exp_t e;
    int   e_edge;
    int   oor;
    @(negedge clk);
    adr_in = a;
    cnt_in = c;
    fv     = 1'b1;
    e_edge = cyc + 1;
    chk("ready_at_issue", longint'(ready), (e_edge >= busy_until) ? 1 : 0);
    if (e_edge >= busy_until) begin
      ref_model(a, c, e.map, e.ncl, oor);
      exp_err = (exp_err + oor > 255) ? 255 : exp_err + oor;
      e.err      = exp_err;
      e.acc_edge = e_edge;
      sb.push_back(e);
      busy_until = e_edge + 9;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fv = 1'b0;
      adr_in = {$urandom, $urandom, $urandom};
      cnt_in = 24'($urandom);
    end
  endtask

  function automatic logic [10:0] rand_adr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 1) return 11'd2047;
    if (r == 2) return 11'(1536 + $urandom_range(0, 510));
    if (r == 3) return 11'(1528 + $urandom_range(0, 7));
    return 11'($urandom_range(0, 1535));
  endfunction

  // Monitor: pops on every strobe, otherwise checks the outputs hold.
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (vpfs_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vpfs_valid: actual 1 required 0 (t=%0t)", $time);
        end else begin
          m_e = sb.pop_front();
          chk_map("vpfs_out", vpfs_out, m_e.map);
          chk("nclusters", longint'(nclusters), m_e.ncl);
          // Strobe is seen in the cycle closing at accept edge + 9.
          chk("latency_edges", cyc + 1 - m_e.acc_edge, 9);
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
          chk("err_cnt", longint'(err_cnt), m_e.err);
`endif
          hold_map = m_e.map;
          hold_ncl = m_e.ncl;
        end
      end else begin
        chk_map("vpfs_out_hold", vpfs_out, hold_map);
        chk("nclusters_hold", longint'(nclusters), hold_ncl);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [87:0] a;
    logic [23:0] c;

    rst = 1'b1;
    fv = 1'b0;
    adr_in = '0;
    cnt_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", longint'(ready), 1);
    chk("rst_vpfs_valid", longint'(vpfs_valid), 0);
    chk("rst_nclusters", longint'(nclusters), 0);
    chk_map("rst_vpfs_out", vpfs_out, '0);
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
    chk("rst_err_cnt", longint'(err_cnt), 0);
`endif
    #2 rst = 1'b0;

    // Single cluster at 10, size 3.
    a = '1; c = '0;
    a[10:0] = 11'd10; c[2:0] = 3'd2;
    issue(a, c); idle(10);

    // Clipped at the top of the map.
    a = '1; c = '0;
    a[10:0] = 11'd1534; c[2:0] = 3'd7;
    issue(a, c); idle(10);

    // Overlap across the 767/768 boundary.
    a = '1; c = '0;
    a[10:0] = 11'd766; c[2:0] = 3'd3;
    a[21:11] = 11'd768; c[5:3] = 3'd0;
    issue(a, c); idle(10);

    // Out-of-range, null, then six clusters at strip 0; repeated back to
    // back until the error counter saturates.
    a = '0; c = '0;
    a[10:0] = 11'd1600;
    a[21:11] = 11'd2047;
    for (int i = 0; i < 300; i++) begin
      issue(a, c);
      idle(8);
    end
    idle(4);

    // Pulse during UNPACK is ignored; a pulse in DONE is taken.
    a = '1; c = '0;
    a[10:0] = 11'd100; c[2:0] = 3'd5;
    issue(a, c);
    idle(2);
    a[10:0] = 11'd200;
    issue(a, c);
    idle(5);
    a[10:0] = 11'd300;
    issue(a, c);
    idle(12);

    // Reset while unpacking slot 4: frame abandoned.
    a = '1; c = '0;
    a[10:0] = 11'd50; c[2:0] = 3'd1;
    issue(a, c);
    idle(5);
    #2 rst = 1'b1;
    sb.delete();
    hold_map = '0;
    hold_ncl = 0;
    exp_err = 0;
    busy_until = 0;
    #1;
    chk("mid_rst_ready", longint'(ready), 1);
    chk("mid_rst_vpfs_valid", longint'(vpfs_valid), 0);
    chk("mid_rst_nclusters", longint'(nclusters), 0);
    chk_map("mid_rst_vpfs_out", vpfs_out, '0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    idle(12);
    a = '1; c = '0;
    a[10:0] = 11'd1535; c[2:0] = 3'd4;
    a[87:77] = 11'd0; c[23:21] = 3'd7;
    issue(a, c); idle(10);

    // Random frames with random gaps (some land mid-UNPACK, some in DONE).
    for (int f = 0; f < 80; f++) begin
      for (int k = 0; k < 8; k++) begin
        a[11*k +: 11] = rand_adr();
        c[3*k +: 3]   = 3'($urandom_range(0, 7));
      end
      issue(a, c);
      idle(int'($urandom_range(1, 12)));
    end

    idle(20);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
